// File: rtl/cfg_bus_demux.sv
// cfg_bus_demux: routes single-outstanding cfg requests from one master to
// NUM_SLV slaves by an address-select field. It also returns ERR_DATA on a
// decode error or a slave timeout, and records protocol and decode errors.
module cfg_bus_demux #(
    parameter int unsigned         NUM_SLV     = 4,
    parameter int unsigned         ADDR_W      = 32,
    parameter int unsigned         DATA_W      = 32,
    parameter int unsigned         SEL_LSB     = 12,
    parameter int unsigned         TIMEOUT_CYC = 256,
    parameter logic [DATA_W-1:0]   ERR_DATA    = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                        clk_main_a0,
    input  logic                        rst_main_n,
    input  logic [ADDR_W-1:0]           m_addr,
    input  logic [DATA_W-1:0]           m_wdata,
    input  logic                        m_wr,
    input  logic                        m_rd,
    output logic                        m_ack,
    output logic [DATA_W-1:0]           m_rdata,
    output logic [NUM_SLV*ADDR_W-1:0]   s_addr,
    output logic [NUM_SLV*DATA_W-1:0]   s_wdata,
    output logic [NUM_SLV-1:0]          s_wr,
    output logic [NUM_SLV-1:0]          s_rd,
    input  logic [NUM_SLV-1:0]          s_ack,
    input  logic [NUM_SLV*DATA_W-1:0]   s_rdata,
    output logic [15:0]                 timeout_cnt,
    output logic [1:0]                  err_sticky
);

    localparam int unsigned SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_nxt_state;

    logic [ADDR_W-1:0]     r_addr,      w_nxt_addr;
    logic [DATA_W-1:0]     r_wdata,     w_nxt_wdata;
    logic [SEL_W-1:0]      r_sel,       w_nxt_sel;
    logic                  r_ack_seen,  w_nxt_ack_seen;
    logic [DATA_W-1:0]     r_rdata_cap, w_nxt_rdata_cap;
    logic [TMO_W-1:0]      r_tmo,       w_nxt_tmo;
    logic [NUM_SLV-1:0]    r_s_wr,      w_nxt_s_wr;
    logic [NUM_SLV-1:0]    r_s_rd,      w_nxt_s_rd;
    logic                  r_m_ack,     w_nxt_m_ack;
    logic [DATA_W-1:0]     r_m_rdata,   w_nxt_m_rdata;
    logic [15:0]           r_tcnt,      w_nxt_tcnt;
    logic [1:0]            r_err,       w_nxt_err;

    logic                  w_req;
    logic [SEL_W-1:0]      w_req_sel;
    logic [NUM_SLV-1:0]    w_req_onehot;
    logic                  w_sel_ok;
    logic                  w_ack_sel;
    logic [DATA_W-1:0]     w_rdata_sel;

    assign w_req     = m_wr | m_rd;
    assign w_req_sel = m_addr[SEL_LSB +: SEL_W];
    assign w_sel_ok  = (32'(r_sel) < NUM_SLV);

    // One-hot strobe pattern for an incoming request; all-zero on a decode miss
    always_comb begin
        w_req_onehot = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            w_req_onehot[i] = (w_req_sel == SEL_W'(i));
        end
    end

    // Ack and read data of the currently selected slave
    always_comb begin
        w_ack_sel   = 1'b0;
        w_rdata_sel = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_ack_sel   = s_ack[i];
                w_rdata_sel = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-value logic for every registered output
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_addr      = r_addr;
        w_nxt_wdata     = r_wdata;
        w_nxt_sel       = r_sel;
        w_nxt_ack_seen  = r_ack_seen;
        w_nxt_rdata_cap = r_rdata_cap;
        w_nxt_tmo       = r_tmo;
        w_nxt_s_wr      = '0;
        w_nxt_s_rd      = '0;
        w_nxt_m_ack     = 1'b0;
        w_nxt_m_rdata   = r_m_rdata;
        w_nxt_tcnt      = r_tcnt;
        w_nxt_err       = r_err;

        // A request arriving while busy is dropped and flagged
        if (w_req && (r_state != ST_IDLE)) begin
            w_nxt_err[0] = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_nxt_addr     = m_addr;
                    w_nxt_wdata    = m_wdata;
                    w_nxt_sel      = w_req_sel;
                    w_nxt_ack_seen = 1'b0;
                    // Strobe is registered so it lands exactly in the ISSUE cycle
                    if (m_wr) begin
                        w_nxt_s_wr = w_req_onehot;
                    end else begin
                        w_nxt_s_rd = w_req_onehot;
                    end
                    w_nxt_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_nxt_tmo = '0;
                if (w_sel_ok) begin
                    // An ack in the strobe cycle is remembered and honoured in WAIT
                    if (w_ack_sel) begin
                        w_nxt_ack_seen  = 1'b1;
                        w_nxt_rdata_cap = w_rdata_sel;
                    end
                    w_nxt_state = ST_WAIT;
                end else begin
                    w_nxt_err[1]  = 1'b1;
                    w_nxt_m_ack   = 1'b1;
                    w_nxt_m_rdata = ERR_DATA;
                    w_nxt_state   = ST_RESP;
                end
            end
            ST_WAIT: begin
                w_nxt_tmo = r_tmo + TMO_W'(1);
                if (r_ack_seen) begin
                    w_nxt_m_ack   = 1'b1;
                    w_nxt_m_rdata = r_rdata_cap;
                    w_nxt_state   = ST_RESP;
                end else if (w_ack_sel) begin
                    w_nxt_m_ack   = 1'b1;
                    w_nxt_m_rdata = w_rdata_sel;
                    w_nxt_state   = ST_RESP;
                end else if ((TIMEOUT_CYC > 0) && (r_tmo == TMO_W'(TIMEOUT_CYC - 1))) begin
                    w_nxt_m_ack   = 1'b1;
                    w_nxt_m_rdata = ERR_DATA;
                    if (r_tcnt != 16'hFFFF) begin
                        w_nxt_tcnt = r_tcnt + 16'd1;
                    end
                    w_nxt_state   = ST_RESP;
                end
            end
            ST_RESP: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Request, response and status registers
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_sel       <= '0;
            r_ack_seen  <= 1'b0;
            r_rdata_cap <= '0;
            r_tmo       <= '0;
            r_s_wr      <= '0;
            r_s_rd      <= '0;
            r_m_ack     <= 1'b0;
            r_m_rdata   <= '0;
            r_tcnt      <= '0;
            r_err       <= '0;
        end else begin
            r_addr      <= w_nxt_addr;
            r_wdata     <= w_nxt_wdata;
            r_sel       <= w_nxt_sel;
            r_ack_seen  <= w_nxt_ack_seen;
            r_rdata_cap <= w_nxt_rdata_cap;
            r_tmo       <= w_nxt_tmo;
            r_s_wr      <= w_nxt_s_wr;
            r_s_rd      <= w_nxt_s_rd;
            r_m_ack     <= w_nxt_m_ack;
            r_m_rdata   <= w_nxt_m_rdata;
            r_tcnt      <= w_nxt_tcnt;
            r_err       <= w_nxt_err;
        end
    end

    // Every slave slice carries the captured request; only the strobes are per-slave
    assign s_addr      = {NUM_SLV{r_addr}};
    assign s_wdata     = {NUM_SLV{r_wdata}};
    assign s_wr        = r_s_wr;
    assign s_rd        = r_s_rd;
    assign m_ack       = r_m_ack;
    assign m_rdata     = r_m_rdata;
    assign timeout_cnt = r_tcnt;
    assign err_sticky  = r_err;

endmodule

// File: tb/tb_cfg_bus_demux.sv
// Directed bench for cfg_bus_demux: a 4-slave instance with a 16-cycle timeout,
// and a 3-slave instance for the decode-error path.
module tb_cfg_bus_demux;

    logic         clk;
    logic         rst_n;

    logic [31:0]  m_addr, m_wdata;
    logic         m_wr, m_rd, m_ack;
    logic [31:0]  m_rdata;
    logic [127:0] s_addr, s_wdata, s_rdata;
    logic [3:0]   s_wr, s_rd, s_ack;
    logic [15:0]  tcnt;
    logic [1:0]   err;

    logic [31:0]  m3_addr, m3_wdata;
    logic         m3_wr, m3_rd, m3_ack;
    logic [31:0]  m3_rdata;
    logic [95:0]  s3_addr, s3_wdata, s3_rdata;
    logic [2:0]   s3_wr, s3_rd, s3_ack;
    logic [15:0]  tcnt3;
    logic [1:0]   err3;

    int n_vec = 0;
    int n_err = 0;

    cfg_bus_demux #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32), .SEL_LSB(12), .TIMEOUT_CYC(16)) u_dut (
        .clk_main_a0(clk), .rst_main_n(rst_n),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wr(m_wr), .m_rd(m_rd),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wr(s_wr), .s_rd(s_rd),
        .s_ack(s_ack), .s_rdata(s_rdata),
        .timeout_cnt(tcnt), .err_sticky(err)
    );

    cfg_bus_demux #(.NUM_SLV(3), .ADDR_W(32), .DATA_W(32), .SEL_LSB(12), .TIMEOUT_CYC(16)) u_dut3 (
        .clk_main_a0(clk), .rst_main_n(rst_n),
        .m_addr(m3_addr), .m_wdata(m3_wdata), .m_wr(m3_wr), .m_rd(m3_rd),
        .m_ack(m3_ack), .m_rdata(m3_rdata),
        .s_addr(s3_addr), .s_wdata(s3_wdata), .s_wr(s3_wr), .s_rd(s3_rd),
        .s_ack(s3_ack), .s_rdata(s3_rdata),
        .timeout_cnt(tcnt3), .err_sticky(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Overall time limit so the run can never hang
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        m_addr = '0; m_wdata = '0; m_wr = 1'b0; m_rd = 1'b0;
        s_ack = '0; s_rdata = '0;
        m3_addr = '0; m3_wdata = '0; m3_wr = 1'b0; m3_rd = 1'b0;
        s3_ack = '0; s3_rdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_m_ack",   64'(m_ack),   64'h0);
        chk("rst_m_rdata", 64'(m_rdata), 64'h0);
        chk("rst_strobes", 64'({s_wr, s_rd}), 64'h0);
        chk("rst_tcnt",    64'(tcnt),    64'h0);
        chk("rst_err",     64'(err),     64'h0);
        chk("rst_s_addr",  64'(s_addr[63:0]), 64'h0);
        chk("rst_dut3",    64'({s3_wr, s3_rd, m3_ack, err3, tcnt3}), 64'h0);
        chk("rst_dut3_bus", 64'(s3_addr[31:0] ^ s3_wdata[31:0] ^ m3_rdata), 64'h0);
        rst_n = 1'b1;
        tick();

        // Read slave 2, ack three cycles after the s_rd strobe
        m_addr = 32'h0000_2010; m_rd = 1'b1;
        tick();                                     // c1: ISSUE
        m_rd = 1'b0;
        chk("rd2_s_rd",   64'(s_rd), 64'h4);
        chk("rd2_s_wr",   64'(s_wr), 64'h0);
        chk("rd2_s_addr", 64'(s_addr[2*32 +: 32]), 64'h0000_2010);
        tick();                                     // c2
        chk("rd2_s_rd_one", 64'(s_rd), 64'h0);
        tick();                                     // c3
        tick();                                     // c4
        chk("rd2_no_early_ack", 64'(m_ack), 64'h0);
        s_ack = 4'b0100; s_rdata[2*32 +: 32] = 32'h1234_5678;
        tick();                                     // c5
        s_ack = '0;
        chk("rd2_m_ack",   64'(m_ack),   64'h1);
        chk("rd2_m_rdata", 64'(m_rdata), 64'h1234_5678);
        tick();                                     // c6
        chk("rd2_ack_pulse", 64'(m_ack),   64'h0);
        chk("rd2_hold",      64'(m_rdata), 64'h1234_5678);

        // Write slave 3, ack in the strobe cycle
        m_addr = 32'h0000_3004; m_wdata = 32'hA5A5_A5A5; m_wr = 1'b1;
        tick();                                     // c1
        m_wr = 1'b0;
        chk("wr3_s_wr",    64'(s_wr), 64'h8);
        chk("wr3_s_rd",    64'(s_rd), 64'h0);
        chk("wr3_s_wdata", 64'(s_wdata[3*32 +: 32]), 64'hA5A5_A5A5);
        s_ack = 4'b1000; s_rdata[3*32 +: 32] = 32'h0BAD_F00D;
        tick();                                     // c2
        s_ack = '0;
        chk("wr3_no_early_ack", 64'(m_ack), 64'h0);
        tick();                                     // c3
        chk("wr3_m_ack",   64'(m_ack),   64'h1);
        chk("wr3_m_rdata", 64'(m_rdata), 64'h0BAD_F00D);
        tick();

        // Read slave 1 with no ack: timeout after 16 WAIT cycles
        m_addr = 32'h0000_1000; m_rd = 1'b1;
        tick();                                     // c1
        m_rd = 1'b0;
        chk("tmo_s_rd", 64'(s_rd), 64'h2);
        for (int c = 2; c <= 17; c++) tick();       // c17: last WAIT cycle
        chk("tmo_not_yet", 64'(m_ack), 64'h0);
        tick();                                     // c18
        chk("tmo_m_ack",   64'(m_ack),   64'h1);
        chk("tmo_m_rdata", 64'(m_rdata), 64'hDEAD_BEEF);
        chk("tmo_cnt",     64'(tcnt),    64'h1);
        tick();                                     // c19
        tick();                                     // c20: late ack
        s_ack = 4'b0010; s_rdata[1*32 +: 32] = 32'h5555_AAAA;
        tick();
        s_ack = '0;
        chk("late_ack_ignored", 64'(m_ack), 64'h0);
        tick();
        chk("late_ack_ignored2", 64'(m_ack),   64'h0);
        chk("late_ack_rdata",    64'(m_rdata), 64'hDEAD_BEEF);
        chk("late_ack_err",      64'(err),     64'h0);

        // Extra request and wrong-slave ack during WAIT are ignored
        m_addr = 32'h0000_1008; m_rd = 1'b1;
        tick();                                     // c1
        m_rd = 1'b0;
        chk("busy_s_rd", 64'(s_rd), 64'h2);
        tick();                                     // c2: WAIT
        m_addr = 32'h0000_0000; m_rd = 1'b1;
        s_ack = 4'b0001; s_rdata[0 +: 32] = 32'h1111_1111;
        tick();                                     // c3
        m_rd = 1'b0; s_ack = '0;
        chk("busy_err",    64'(err),   64'h1);
        chk("busy_no_ack", 64'(m_ack), 64'h0);
        chk("busy_no_strobe", 64'({s_wr, s_rd}), 64'h0);
        tick();                                     // c4
        s_ack = 4'b0010; s_rdata[1*32 +: 32] = 32'hCAFE_0001;
        tick();                                     // c5
        s_ack = '0;
        chk("busy_m_ack",   64'(m_ack),   64'h1);
        chk("busy_m_rdata", 64'(m_rdata), 64'hCAFE_0001);
        tick();                                     // c6
        chk("busy_dropped", 64'({m_ack, s_wr, s_rd}), 64'h0);
        chk("busy_tcnt",    64'(tcnt), 64'h1);

        // Simultaneous write and read strobes act as a write
        m_addr = 32'h0000_0000; m_wdata = 32'h0000_0055; m_wr = 1'b1; m_rd = 1'b1;
        tick();                                     // c1
        m_wr = 1'b0; m_rd = 1'b0;
        chk("wrrd_s_wr", 64'(s_wr), 64'h1);
        chk("wrrd_s_rd", 64'(s_rd), 64'h0);
        s_ack = 4'b0001; s_rdata[0 +: 32] = 32'h0000_00AA;
        tick();                                     // c2
        s_ack = '0;
        tick();                                     // c3
        chk("wrrd_m_ack", 64'(m_ack), 64'h1);
        chk("wrrd_err",   64'(err),   64'h1);
        tick();

        // Ack lands in the timeout cycle: ack wins
        m_addr = 32'h0000_2000; m_rd = 1'b1;
        tick();                                     // c1
        m_rd = 1'b0;
        for (int c = 2; c <= 17; c++) tick();       // c17
        s_ack = 4'b0100; s_rdata[2*32 +: 32] = 32'h0000_0077;
        tick();                                     // c18
        s_ack = '0;
        chk("race_m_ack",   64'(m_ack),   64'h1);
        chk("race_m_rdata", 64'(m_rdata), 64'h0000_0077);
        chk("race_tcnt",    64'(tcnt),    64'h1);
        tick();

        // Decode error on the 3-slave instance
        m3_addr = 32'h0000_3000; m3_rd = 1'b1;
        tick();                                     // c1
        m3_rd = 1'b0;
        chk("dec_no_strobe", 64'({s3_wr, s3_rd}), 64'h0);
        chk("dec_no_early",  64'(m3_ack), 64'h0);
        tick();                                     // c2
        chk("dec_m_ack",   64'(m3_ack),   64'h1);
        chk("dec_m_rdata", 64'(m3_rdata), 64'hDEAD_BEEF);
        chk("dec_err",     64'(err3),     64'h2);
        tick();
        chk("dec_ack_pulse", 64'(m3_ack), 64'h0);

        // Reset during WAIT aborts the transaction
        m_addr = 32'h0000_3000; m_rd = 1'b1;
        tick();                                     // c1
        m_rd = 1'b0;
        chk("abort_s_rd", 64'(s_rd), 64'h8);
        tick();                                     // c2: WAIT
        rst_n = 1'b0;
        #1;
        chk("abort_outs",    64'({m_ack, s_wr, s_rd, err}), 64'h0);
        chk("abort_m_rdata", 64'(m_rdata), 64'h0);
        chk("abort_tcnt",    64'(tcnt),    64'h0);
        chk("abort_s_addr",  64'(s_addr[3*32 +: 32]), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        s_ack = 4'b1000; s_rdata[3*32 +: 32] = 32'h9999_9999;
        tick();
        s_ack = '0;
        chk("abort_late_ack", 64'(m_ack), 64'h0);
        tick();
        chk("abort_late_ack2", 64'({m_ack, s_wr, s_rd}), 64'h0);

        // Next request after reset completes normally
        m_addr = 32'h0000_0004; m_rd = 1'b1;
        tick();                                     // c1
        m_rd = 1'b0;
        chk("post_s_rd", 64'(s_rd), 64'h1);
        tick();                                     // c2
        s_ack = 4'b0001; s_rdata[0 +: 32] = 32'h0F0F_0F0F;
        tick();                                     // c3
        s_ack = '0;
        chk("post_m_ack",   64'(m_ack),   64'h1);
        chk("post_m_rdata", 64'(m_rdata), 64'h0F0F_0F0F);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
